// File: rtl/mmu_host_ctrl_pkg.sv
// Shared types and defaults for the matrix-multiply host sequencer.
// The state encoding lives here so the bench can decode state probes.
package mmu_host_ctrl_pkg;

  localparam int MAT_SIZE   = 6;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_KICK    = 3'd2,
    S_COMPUTE = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_OUT     = 3'd6,
    S_FIN     = 3'd7
  } state_e;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmu_out_stage.sv
// Single-entry output register: captures a C row on load and holds it,
// together with its last flag, until the host accepts it.
module mmu_out_stage #(
  parameter int DW = 96
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          last_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic          last_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic          last_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      // NOTE: this is a single row register rather than a memory array, so it
      // is cheap to reset and lets out_data read as zero straight out of reset.
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mmu_host_ctrl.sv
// Host-side sequencer: loads A and B rows into BRAM, kicks the DMA
// controller, waits for completion under a timeout, then streams out C rows.
module mmu_host_ctrl
  import mmu_host_ctrl_pkg::*;
#(
  parameter int N         = MAT_SIZE,
  parameter int WIDTH     = DATA_WIDTH,
  parameter int ADDR      = clog2_min1(N),
  parameter int START_LEN = 3,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 A_USR_wr,
  output logic [ADDR-1:0]      A_USR_addr,
  output logic [N*WIDTH-1:0]   A_USR_din,
  output logic                 B_USR_wr,
  output logic [ADDR-1:0]      B_USR_addr,
  output logic [N*WIDTH-1:0]   B_USR_din,
  output logic                 C_USR_rd,
  output logic [ADDR-1:0]      C_USR_addr,
  input  logic [N*WIDTH-1:0]   C_USR_dout,
  output logic                 start,
  input  logic                 mat_done
);

  localparam int DW    = N * WIDTH;
  localparam int CNT_W = clog2_min1((TIMEOUT > START_LEN) ? TIMEOUT : START_LEN);

  localparam logic [ADDR-1:0]  ROW_LAST  = ADDR'(N - 1);
  localparam logic [CNT_W-1:0] KICK_LAST = CNT_W'(START_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [ADDR-1:0]  row_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             start_q;
  logic             c_rd_q;
  logic             done_q;
  logic             err_q;

  logic in_hs;
  logic out_hs;
  logic row_last;

  assign in_hs    = in_valid && in_ready_q;
  assign out_hs   = out_valid && out_ready;
  assign row_last = (row_q == ROW_LAST);

  // BRAM write ports follow the host handshake in the same cycle.
  assign A_USR_wr   = in_hs && (state_q == S_LOAD_A);
  assign A_USR_addr = A_USR_wr ? row_q : '0;
  assign A_USR_din  = A_USR_wr ? in_data : '0;
  assign B_USR_wr   = in_hs && (state_q == S_LOAD_B);
  assign B_USR_addr = B_USR_wr ? row_q : '0;
  assign B_USR_din  = B_USR_wr ? in_data : '0;
  assign C_USR_rd   = c_rd_q;
  assign C_USR_addr = c_rd_q ? row_q : '0;

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign start    = start_q;
  assign done     = done_q;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD_A;
      row_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      c_rd_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all branches see pre-edge values
      // and the outputs change together with the state they belong to.
      done_q <= 1'b0;
      case (state_q)
        S_LOAD_A: if (in_hs) begin
          busy_q <= 1'b1;
          if (row_q == '0) err_q <= 1'b0;
          if (row_last) begin
            row_q   <= '0;
            state_q <= S_LOAD_B;
          end else begin
            row_q <= row_q + ADDR'(1);
          end
        end
        S_LOAD_B: if (in_hs) begin
          if (row_last) begin
            row_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= S_KICK;
          end else begin
            row_q <= row_q + ADDR'(1);
          end
        end
        S_KICK: begin
          if (cnt_q == KICK_LAST) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
            state_q <= S_COMPUTE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_COMPUTE: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (mat_done) begin
            cnt_q   <= '0;
            row_q   <= '0;
            c_rd_q  <= 1'b1;
            state_q <= S_RD_REQ;
          end else if (cnt_q == TO_LAST) begin
            cnt_q      <= '0;
            row_q      <= '0;
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_LOAD_A;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RD_REQ: begin
          c_rd_q  <= 1'b0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: state_q <= S_OUT;
        S_OUT: if (out_hs) begin
          if (row_last) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            row_q   <= row_q + ADDR'(1);
            c_rd_q  <= 1'b1;
            state_q <= S_RD_REQ;
          end
        end
        S_FIN: begin
          row_q      <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_LOAD_A;
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  mmu_out_stage #(
    .DW (DW)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == S_RD_WAIT),
    .last_i  (row_last),
    .data_i  (C_USR_dout),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .last_o  (out_last),
    .data_o  (out_data)
  );

endmodule

// File: doc/mmu_host_ctrl.md
Name: mmu_host_ctrl

Overview:
Host-side sequencer for the matrix multiply unit. It takes a row stream from the host and writes 2N rows (A rows 0..N-1, then B rows 0..N-1) into the BRAM_Matrix user ports. It then pulses start to DMA_Controller and waits for completion, guarded by a timeout. Finally it reads C rows 0..N-1 from the C user port and returns them as a valid/ready stream.

Parameters:
N, `MAT_SIZE (6), matrix dimension; rows per matrix.
WIDTH, `DATA_WIDTH (16), element width.
ADDR, `CLOG2(N) (3), row address width.
START_LEN, 3, cycles that start is held high.
TIMEOUT, 4096, maximum COMPUTE cycles before error; must be >= 2.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  host row valid.
in_ready  out  1  controller accepts a row.
in_data  in  N*WIDTH  host row; element 0 in bits [WIDTH-1:0].
out_valid  out  1  C row valid.
out_ready  in  1  host accepts the C row.
out_data  out  N*WIDTH  C row from C_USR_dout.
out_last  out  1  high with the row-(N-1) beat.
busy  out  1  a transaction is in progress.
done  out  1  one-cycle pulse after the last C row handshake.
err  out  1  sticky timeout flag.
A_USR_wr  out  1  A write strobe.
A_USR_addr  out  ADDR  A write row.
A_USR_din  out  N*WIDTH  A write data.
B_USR_wr  out  1  B write strobe.
B_USR_addr  out  ADDR  B write row.
B_USR_din  out  N*WIDTH  B write data.
C_USR_rd  out  1  C read strobe.
C_USR_addr  out  ADDR  C read row.
C_USR_dout  in  N*WIDTH  C read data, valid 1 cycle after C_USR_rd.
start  out  1  kick to DMA_Controller.
mat_done  in  1  DMA_Controller completion pulse.

Behaviour:
- States: LOAD_A, LOAD_B, KICK, COMPUTE, RD_REQ, RD_WAIT, OUT, FIN. One row counter `row` (ADDR bits), one cycle counter `cnt`.
- Reset state: LOAD_A. row=0, cnt=0. All outputs 0 except in_ready=1.
- LOAD_A / LOAD_B:
  - in_ready=1.
  - On an in_valid&&in_ready handshake, the same cycle drives the matching *_USR_wr=1, *_USR_addr=row, *_USR_din=in_data. These are combinational from the handshake.
  - row increments on each handshake. row==N-1 with a handshake clears row and advances LOAD_A->LOAD_B or LOAD_B->KICK.
  - No handshake means no write and no change.
- KICK: start=1 for exactly START_LEN cycles, counted by cnt. Then cnt=0 and go to COMPUTE. in_ready=0 from KICK onward.
- COMPUTE:
  - cnt counts up each cycle.
  - mat_done=1 -> go to RD_REQ with row=0.
  - cnt==TIMEOUT-1 without mat_done -> err=1, go to LOAD_A, abandon readout.
  - If mat_done and the timeout hit in the same cycle, mat_done wins.
  - mat_done is ignored in every other state.
- RD_REQ: C_USR_rd=1, C_USR_addr=row. Next state RD_WAIT.
- RD_WAIT: register C_USR_dout into out_data. Next state OUT.
- OUT:
  - out_valid=1. out_data is held stable until the handshake. out_last=(row==N-1).
  - On handshake: if row==N-1 go to FIN, else row+1 and go to RD_REQ.
  - Minimum 3 cycles per row.
- FIN: done=1 for one cycle, then LOAD_A.
- busy=0 only in LOAD_A with row==0. Otherwise busy=1.
- err stays set until rst or the next accepted LOAD_A row-0 handshake.
- rst in any state, including mid-load or mid-readout, returns to the reset state next edge. All strobes drop immediately; partial BRAM contents are not restored.
- Address width: rows never exceed N-1, so there is no wrap beyond N.

Decomposition:
- The shared header params.vh holds MAT_SIZE, DATA_WIDTH, CLOG2, and the state encoding localparams (3-bit), shared with the bench for state probes.
- One sub-module, mmu_out_stage: the single-entry output register with valid/ready hold. It captures C_USR_dout on load and holds until handshake.

Test Plan:
- Nominal: stream 12 rows, every A/B row 96'h000600050004000300020001. Expect A/B_USR_wr on rows 0..5 each, then start high exactly 3 cycles. Bench pulses mat_done 20 cycles later with C row i preloaded as 96'h{i repeated}. Expect 6 out beats in order, out_last on beat 5, done 1 cycle after, busy low.
- Host gaps: in_valid toggles every other cycle, out_ready low for 4 cycles on row 2. Expect no duplicated or missed writes, out_data for row 2 stable while stalled, correct row order.
- Timeout with TIMEOUT=16 and mat_done never asserted: err=1 exactly 16 cycles after entering COMPUTE, no C_USR_rd, return to LOAD_A. The next row-0 handshake clears err.
- mat_done on the timeout cycle: readout proceeds and err stays 0. A mat_done pulse during LOAD_B or KICK is ignored.
- rst asserted mid-LOAD_B at row 3, and separately in OUT at row 4: the next cycle shows all strobes 0, in_ready=1, busy=0. A fresh 12-row load completes normally.
